// File: rtl/controlador_memoria_compartilhada_pkg.sv
// Shared types and constants for the shared data/instruction memory controller.
package controlador_memoria_compartilhada_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ESCRITA  = 2'd1,
    LEITURA  = 2'd2,
    RESPOSTA = 2'd3
  } estado_t;

  // Source ids double as bit positions in the arbiter request/grant vectors.
  localparam logic FONTE_INST = 1'b0;
  localparam logic FONTE_DADO = 1'b1;

  localparam int PROFUNDIDADE_PADRAO = 512;
  localparam int LARG_DADOS_PADRAO   = 32;
  localparam int LARG_END_PADRAO     = 32;

endpackage

// File: rtl/controlador_memoria_compartilhada_arbitro_rr2.sv
// Two-input round-robin arbiter; the data port wins unless it also won last time
// and the instruction port is competing.
import controlador_memoria_compartilhada_pkg::*;

module arbitro_rr2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       atualiza,
  output logic [1:0] gnt
);

  logic ultimo_dado_q;
  logic ultimo_dado_d;

  always_comb begin
    gnt             = '0;
    gnt[FONTE_DADO] = req[FONTE_DADO] & ~(ultimo_dado_q & req[FONTE_INST]);
    gnt[FONTE_INST] = req[FONTE_INST] & ~gnt[FONTE_DADO];
    ultimo_dado_d   = ultimo_dado_q;
    if (atualiza && (gnt != 2'b00)) begin
      ultimo_dado_d = gnt[FONTE_DADO];
    end
  end

  // Cleared pointer means "last grant was instruction", so data is favoured.
  always_ff @(posedge clock) begin
    if (reset) begin
      ultimo_dado_q <= 1'b0;
    end else begin
      ultimo_dado_q <= ultimo_dado_d;
    end
  end

endmodule

// File: rtl/controlador_memoria_compartilhada.sv
// Initiator side of the shared memory: arbitrates fetch vs load/store, drives the
// memory strobes and returns data with a one-cycle valid pulse.
import controlador_memoria_compartilhada_pkg::*;

module controlador_memoria_compartilhada #(
  parameter int LARG_DADOS       = LARG_DADOS_PADRAO,
  parameter int LARG_END         = LARG_END_PADRAO,
  parameter int PROFUNDIDADE     = PROFUNDIDADE_PADRAO,
  parameter int LATENCIA_LEITURA = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inst_req,
  input  logic [LARG_END-1:0]   inst_end,
  output logic                  inst_ready,
  output logic                  inst_valido,
  output logic [LARG_DADOS-1:0] inst_dado,
  input  logic                  dado_req,
  input  logic                  dado_esc,
  input  logic [LARG_END-1:0]   dado_end,
  input  logic [LARG_DADOS-1:0] dado_wdata,
  output logic                  dado_ready,
  output logic                  dado_valido,
  output logic [LARG_DADOS-1:0] dado_rdata,
  output logic                  erro_end,
  output logic [LARG_END-1:0]   mem_endereco,
  output logic [LARG_DADOS-1:0] mem_indata,
  output logic                  mem_lerMem,
  output logic                  mem_escMem,
  input  logic [LARG_DADOS-1:0] mem_output
);

  localparam int LARG_CONT = (LATENCIA_LEITURA > 1) ? $clog2(LATENCIA_LEITURA + 1) : 1;
  localparam logic [LARG_END:0] LIMITE = (LARG_END + 1)'(PROFUNDIDADE);

  estado_t               estado_q, estado_d;
  logic [LARG_CONT-1:0]  cont_q, cont_d;
  logic [LARG_END-1:0]   end_q, end_d;
  logic [LARG_DADOS-1:0] wdata_q, wdata_d;
  logic                  fonte_q, fonte_d;
  logic                  erro_q, erro_d;
  logic [LARG_DADOS-1:0] inst_dado_q, inst_dado_d;
  logic [LARG_DADOS-1:0] dado_rdata_q, dado_rdata_d;

  logic                  ocioso;
  logic [1:0]            req;
  logic [1:0]            gnt;
  logic [LARG_END-1:0]   end_sel;

  assign ocioso                = (estado_q == OCIOSO);
  assign req[FONTE_INST]       = inst_req;
  assign req[FONTE_DADO]       = dado_req;

  arbitro_rr2 u_arbitro (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .atualiza (ocioso),
    .gnt      (gnt)
  );

  assign inst_ready   = ocioso & gnt[FONTE_INST];
  assign dado_ready   = ocioso & gnt[FONTE_DADO];
  assign end_sel      = dado_ready ? dado_end : inst_end;

  assign mem_lerMem   = (estado_q == LEITURA);
  assign mem_escMem   = (estado_q == ESCRITA);
  assign mem_endereco = end_q;
  assign mem_indata   = wdata_q;
  assign inst_valido  = (estado_q == RESPOSTA) && (fonte_q == FONTE_INST);
  assign dado_valido  = (estado_q == RESPOSTA) && (fonte_q == FONTE_DADO);
  assign erro_end     = (estado_q == RESPOSTA) && erro_q;
  assign inst_dado    = inst_dado_q;
  assign dado_rdata   = dado_rdata_q;

  always_comb begin
    estado_d     = estado_q;
    cont_d       = cont_q;
    end_d        = end_q;
    wdata_d      = wdata_q;
    fonte_d      = fonte_q;
    erro_d       = erro_q;
    inst_dado_d  = inst_dado_q;
    dado_rdata_d = dado_rdata_q;
    case (estado_q)
      OCIOSO: begin
        if (inst_ready || dado_ready) begin
          fonte_d = dado_ready ? FONTE_DADO : FONTE_INST;
          end_d   = end_sel;
          wdata_d = dado_ready ? dado_wdata : '0;
          cont_d  = LARG_CONT'(LATENCIA_LEITURA);
          if ({1'b0, end_sel} >= LIMITE) begin
            // Out-of-range: skip the memory entirely and answer with zero data.
            erro_d   = 1'b1;
            estado_d = RESPOSTA;
            if (dado_ready) dado_rdata_d = '0;
            else            inst_dado_d  = '0;
          end else begin
            erro_d   = 1'b0;
            estado_d = (dado_ready && dado_esc) ? ESCRITA : LEITURA;
          end
        end
      end
      ESCRITA: begin
        estado_d     = RESPOSTA;
        dado_rdata_d = '0;
      end
      LEITURA: begin
        if (cont_q == '0) begin
          estado_d = RESPOSTA;
          if (fonte_q == FONTE_INST) inst_dado_d  = mem_output;
          else                       dado_rdata_d = mem_output;
        end else begin
          cont_d = cont_q - 1'b1;
        end
      end
      RESPOSTA: estado_d = OCIOSO;
      default:  estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= OCIOSO;
      cont_q       <= '0;
      end_q        <= '0;
      wdata_q      <= '0;
      fonte_q      <= FONTE_DADO;
      erro_q       <= 1'b0;
      inst_dado_q  <= '0;
      dado_rdata_q <= '0;
    end else begin
      estado_q     <= estado_d;
      cont_q       <= cont_d;
      end_q        <= end_d;
      wdata_q      <= wdata_d;
      fonte_q      <= fonte_d;
      erro_q       <= erro_d;
      inst_dado_q  <= inst_dado_d;
      dado_rdata_q <= dado_rdata_d;
    end
  end

endmodule

// File: tb/tb_controlador_memoria_compartilhada.sv
// Directed bench: default-latency instance with a 512-word memory model, plus a
// latency-3 instance for the fetch timing case.
module tb_controlador_memoria_compartilhada;

  logic        clock = 1'b0;
  logic        reset;
  logic        inst_req, dado_req, dado_esc;
  logic [31:0] inst_end, dado_end, dado_wdata;
  logic        inst_ready, inst_valido, dado_ready, dado_valido, erro_end;
  logic [31:0] inst_dado, dado_rdata, mem_endereco, mem_indata, mem_output;
  logic        mem_lerMem, mem_escMem;

  logic        inst_req3;
  logic [31:0] inst_end3;
  logic        inst_ready3, inst_valido3, dado_ready3, dado_valido3, erro_end3;
  logic [31:0] inst_dado3, dado_rdata3, mem_endereco3, mem_indata3, mem_output3;
  logic        mem_lerMem3, mem_escMem3;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'd0;

  logic [31:0] mem [0:511];
  int total  = 0;
  int passed = 0;

  always #5 clock = ~clock;

  controlador_memoria_compartilhada u_dut (
    .clock(clock), .reset(reset),
    .inst_req(inst_req), .inst_end(inst_end), .inst_ready(inst_ready),
    .inst_valido(inst_valido), .inst_dado(inst_dado),
    .dado_req(dado_req), .dado_esc(dado_esc), .dado_end(dado_end),
    .dado_wdata(dado_wdata), .dado_ready(dado_ready), .dado_valido(dado_valido),
    .dado_rdata(dado_rdata), .erro_end(erro_end),
    .mem_endereco(mem_endereco), .mem_indata(mem_indata),
    .mem_lerMem(mem_lerMem), .mem_escMem(mem_escMem), .mem_output(mem_output)
  );

  controlador_memoria_compartilhada #(.LATENCIA_LEITURA(3)) u_dut3 (
    .clock(clock), .reset(reset),
    .inst_req(inst_req3), .inst_end(inst_end3), .inst_ready(inst_ready3),
    .inst_valido(inst_valido3), .inst_dado(inst_dado3),
    .dado_req(zero1), .dado_esc(zero1), .dado_end(zero32),
    .dado_wdata(zero32), .dado_ready(dado_ready3), .dado_valido(dado_valido3),
    .dado_rdata(dado_rdata3), .erro_end(erro_end3),
    .mem_endereco(mem_endereco3), .mem_indata(mem_indata3),
    .mem_lerMem(mem_lerMem3), .mem_escMem(mem_escMem3), .mem_output(mem_output3)
  );

  function automatic logic [31:0] padrao(input int i);
    return 32'hA5000000 | 32'(i);
  endfunction

  // Memory model: one-cycle registered read, reloaded with a known pattern on reset.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 512; i++) mem[i] <= padrao(i);
      mem_output <= '0;
    end else begin
      if (mem_escMem) mem[mem_endereco[8:0]] <= mem_indata;
      mem_output <= mem_lerMem ? mem[mem_endereco[8:0]] : '0;
    end
  end

  always @(posedge clock) begin
    if (reset) mem_output3 <= '0;
    else if (mem_lerMem3) mem_output3 <= (mem_endereco3 == 32'd0) ? 32'h20080001 : 32'h0;
    else mem_output3 <= '0;
  end

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic ir, dr, ai, ad, exp_d;
  int   n;

  initial begin
    reset = 1'b1;
    inst_req = 0; inst_end = 0; dado_req = 0; dado_esc = 0; dado_end = 0; dado_wdata = 0;
    inst_req3 = 0; inst_end3 = 0;
    tick(); tick();
    reset = 1'b0;
    #1;
    verifica("rst_lerMem", {31'd0, mem_lerMem}, 32'd0);
    verifica("rst_escMem", {31'd0, mem_escMem}, 32'd0);
    verifica("rst_readys", {30'd0, inst_ready, dado_ready}, 32'd0);
    verifica("rst_valids", {29'd0, inst_valido, dado_valido, erro_end}, 32'd0);
    verifica("rst_endereco", mem_endereco, 32'd0);
    verifica("rst_indata", mem_indata, 32'd0);
    verifica("rst_inst_dado", inst_dado, 32'd0);
    verifica("rst_dado_rdata", dado_rdata, 32'd0);

    // Store 0xDEADBEEF at 5.
    dado_req = 1; dado_esc = 1; dado_end = 5; dado_wdata = 32'hDEADBEEF;
    #1;
    verifica("st_ready", {30'd0, inst_ready, dado_ready}, 32'd1);
    tick(); dado_req = 0;
    verifica("st_t1_escMem", {31'd0, mem_escMem}, 32'd1);
    verifica("st_t1_lerMem", {31'd0, mem_lerMem}, 32'd0);
    verifica("st_t1_end", mem_endereco, 32'd5);
    verifica("st_t1_indata", mem_indata, 32'hDEADBEEF);
    verifica("st_t1_valido", {31'd0, dado_valido}, 32'd0);
    tick();
    verifica("st_t2_valido", {31'd0, dado_valido}, 32'd1);
    verifica("st_t2_erro", {31'd0, erro_end}, 32'd0);
    verifica("st_t2_rdata", dado_rdata, 32'd0);
    verifica("st_t2_escMem", {31'd0, mem_escMem}, 32'd0);
    tick();
    verifica("st_t3_valido", {31'd0, dado_valido}, 32'd0);

    // Load 5.
    dado_req = 1; dado_esc = 0; dado_end = 5;
    #1;
    verifica("ld_ready", {31'd0, dado_ready}, 32'd1);
    tick(); dado_req = 0;
    verifica("ld_t1_lerMem", {31'd0, mem_lerMem}, 32'd1);
    verifica("ld_t1_end", mem_endereco, 32'd5);
    tick();
    verifica("ld_t2_lerMem", {31'd0, mem_lerMem}, 32'd1);
    verifica("ld_t2_valido", {31'd0, dado_valido}, 32'd0);
    tick();
    verifica("ld_t3_lerMem", {31'd0, mem_lerMem}, 32'd0);
    verifica("ld_t3_valido", {31'd0, dado_valido}, 32'd1);
    verifica("ld_t3_rdata", dado_rdata, 32'hDEADBEEF);
    verifica("ld_t3_erro", {31'd0, erro_end}, 32'd0);
    tick();

    // Conflicts after reset: data, inst, data, inst.
    reset = 1; tick(); reset = 0;
    inst_req = 1; inst_end = 10; dado_req = 1; dado_esc = 0; dado_end = 20;
    #1;
    exp_d = 1'b1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(inst_ready || dado_ready) && n < 20) begin
        tick();
        n++;
      end
      verifica("rr_dado_ready", {31'd0, dado_ready}, {31'd0, exp_d});
      verifica("rr_inst_ready", {31'd0, inst_ready}, {31'd0, ~exp_d});
      tick();
      exp_d = ~exp_d;
    end
    inst_req = 0; dado_req = 0;
    for (int k = 0; k < 6; k++) tick();
    verifica("rr_inst_dado", inst_dado, padrao(10));
    verifica("rr_dado_rdata", dado_rdata, padrao(20));

    // Out-of-range load at 512.
    dado_req = 1; dado_esc = 0; dado_end = 512;
    #1;
    verifica("oor_ready", {31'd0, dado_ready}, 32'd1);
    tick(); dado_req = 0;
    verifica("oor_t1_valido", {31'd0, dado_valido}, 32'd1);
    verifica("oor_t1_erro", {31'd0, erro_end}, 32'd1);
    verifica("oor_t1_rdata", dado_rdata, 32'd0);
    verifica("oor_t1_strobes", {30'd0, mem_lerMem, mem_escMem}, 32'd0);
    tick();
    verifica("oor_t2_valido", {31'd0, dado_valido}, 32'd0);
    verifica("oor_t2_erro", {31'd0, erro_end}, 32'd0);
    verifica("oor_t2_strobes", {30'd0, mem_lerMem, mem_escMem}, 32'd0);

    // Last legal address 511.
    dado_req = 1; dado_end = 511;
    #1;
    tick(); dado_req = 0;
    verifica("b511_t1_lerMem", {31'd0, mem_lerMem}, 32'd1);
    tick(); tick();
    verifica("b511_t3_valido", {31'd0, dado_valido}, 32'd1);
    verifica("b511_t3_erro", {31'd0, erro_end}, 32'd0);
    verifica("b511_t3_rdata", dado_rdata, padrao(511));
    tick();

    // Reset during the first read strobe cycle.
    dado_req = 1; dado_end = 7;
    #1;
    tick(); dado_req = 0;
    verifica("rmr_t1_lerMem", {31'd0, mem_lerMem}, 32'd1);
    reset = 1; tick(); reset = 0;
    #1;
    verifica("rmr_lerMem", {31'd0, mem_lerMem}, 32'd0);
    verifica("rmr_escMem", {31'd0, mem_escMem}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      verifica("rmr_no_valido", {30'd0, dado_valido, inst_valido}, 32'd0);
      tick();
    end
    dado_req = 1; dado_end = 7;
    #1;
    verifica("rmr_ready", {31'd0, dado_ready}, 32'd1);
    tick(); dado_req = 0;
    tick(); tick();
    verifica("rmr_valido", {31'd0, dado_valido}, 32'd1);
    verifica("rmr_rdata", dado_rdata, padrao(7));
    tick();

    // Latency-3 fetch from address 0.
    inst_req3 = 1; inst_end3 = 0;
    #1;
    verifica("l3_ready", {31'd0, inst_ready3}, 32'd1);
    tick(); inst_req3 = 0;
    for (int k = 1; k <= 4; k++) begin
      verifica("l3_lerMem", {31'd0, mem_lerMem3}, 32'd1);
      verifica("l3_no_valido", {31'd0, inst_valido3}, 32'd0);
      tick();
    end
    verifica("l3_t5_lerMem", {31'd0, mem_lerMem3}, 32'd0);
    verifica("l3_t5_valido", {31'd0, inst_valido3}, 32'd1);
    verifica("l3_t5_dado", inst_dado3, 32'h20080001);
    verifica("l3_t5_erro", {31'd0, erro_end3}, 32'd0);
    tick();

    // Random traffic with invariant checks.
    ir = 0; dr = 0;
    for (int i = 0; i < 300; i++) begin
      if (!ir) begin
        ir = 1'($urandom_range(0, 1));
        inst_end = 32'($urandom_range(0, 600));
      end
      if (!dr) begin
        dr = 1'($urandom_range(0, 1));
        dado_end = 32'($urandom_range(0, 600));
        dado_esc = 1'($urandom_range(0, 1));
        dado_wdata = $urandom;
      end
      inst_req = ir; dado_req = dr;
      #1;
      verifica("inv_strobes", {31'd0, mem_lerMem & mem_escMem}, 32'd0);
      verifica("inv_readys", {31'd0, inst_ready & dado_ready}, 32'd0);
      verifica("inv_ready_busy",
               {31'd0, (inst_ready | dado_ready) & (mem_lerMem | mem_escMem | inst_valido | dado_valido)},
               32'd0);
      ai = inst_ready; ad = dado_ready;
      tick();
      if (ai) ir = 0;
      if (ad) dr = 0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
